// File: rtl/puf_hex_sender.sv
// puf_hex_sender: turns one PUF response word into uppercase ASCII hex
// characters (most significant nibble first) followed by CR LF. Characters
// are handed to a UART transmitter one at a time. The transmitter has no
// busy or done signal, so starts are paced by a fixed inter-start gap.
module puf_hex_sender #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int BYTE_GAP   = (CLK_FREQ / BAUD_RATE) * 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  busy
);

  localparam int NHEX  = DATA_WIDTH / 4;
  localparam int NCHAR = NHEX + 2;
  localparam int CNT_W = $clog2(BYTE_GAP + 1);
  localparam int IDX_W = $clog2(NCHAR);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHAR - 1);
  localparam logic [IDX_W-1:0] IDX_CR   = IDX_W'(NHEX);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] shift_next_s;
  logic [IDX_W-1:0]      idx_next_s;

  // Map a 4-bit value to its uppercase ASCII hex digit.
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = 8'h30 + {4'h0, nib};
    end else begin
      res = 8'h37 + {4'h0, nib};
    end
    return res;
  endfunction

  // Character for a given position; hex digits come from the top nibble of
  // the already-shifted word, then CR, then LF.
  function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx,
                                         input logic [DATA_WIDTH-1:0] word);
    logic [7:0] res;
    if (idx < IDX_CR) begin
      res = nib2hex(word[DATA_WIDTH-1 -: 4]);
    end else if (idx == IDX_CR) begin
      res = 8'h0D;
    end else begin
      res = 8'h0A;
    end
    return res;
  endfunction

  assign shift_next_s = shift_q << 4;
  assign idx_next_s   = idx_q + IDX_ONE;

  // Next-state logic: handshake, character sequencing and gap pacing.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_SEND;
          shift_d   = in_data;
          idx_d     = IDX_ZERO;
          tx_data_d = nib2hex(in_data[DATA_WIDTH-1 -: 4]);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
      end
      ST_GAP: begin
        // Leaving when the count reaches zero keeps SEND-to-SEND at BYTE_GAP.
        if (cnt_q <= CNT_ONE) begin
          cnt_d = CNT_ZERO;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_SEND;
            idx_d     = idx_next_s;
            shift_d   = shift_next_s;
            tx_data_d = char_at(idx_next_s, shift_next_s);
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs follow the next state so
  // they are aligned with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= IDX_ZERO;
      cnt_q      <= CNT_ZERO;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= (state_d == ST_SEND);
      in_ready_q <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign in_ready = in_ready_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;

endmodule

// File: doc/puf_hex_sender.md
# puf_hex_sender

Upstream framing stage for the UART transmitter. Accepts one PUF response word over a valid/ready handshake, converts it to uppercase ASCII hex (MSB nibble first), appends CR LF, and presents the characters one at a time as `tx_data` with a one-cycle `tx_start` pulse. The downstream transmitter has no busy or done indication, so this block paces bytes with a fixed inter-start gap counter. That gap is the only flow control on the byte interface.

## Interface
Parameters:
- `DATA_WIDTH`, 32: response word width; must be a multiple of 4 and at least 4.
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in Hz.
- `BYTE_GAP`, (CLK_FREQ/BAUD_RATE)*12: clock cycles from one `tx_start` pulse to the next; must be at least 10*(CLK_FREQ/BAUD_RATE)+2.

Ports:
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, DATA_WIDTH: response word to send.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block can accept a word; high only in IDLE.
- `tx_data`, out, 8: ASCII character for the transmitter.
- `tx_start`, out, 1: one-cycle pulse; `tx_data` is valid in that cycle.
- `busy`, out, 1: high from word acceptance until return to IDLE.

## Operation
- NCHAR = DATA_WIDTH/4 + 2 characters per word: hex digits from bits [DATA_WIDTH-1:DATA_WIDTH-4] down to [3:0], then 0x0D, then 0x0A.
- Nibble encoding: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46 (uppercase only).
- The word is captured into an internal shift register at acceptance. Later changes on `in_data` have no effect.
- States:
  - IDLE: `in_ready`=1, `busy`=0. When `in_valid`=1, capture the word, clear the char index, go to SEND.
  - SEND: drive `tx_data` with the current character and pulse `tx_start` for one cycle. Load the gap counter with BYTE_GAP-1 and go to GAP.
  - GAP: decrement the counter. At zero:
    - if the char index is NCHAR-1, go to IDLE;
    - otherwise increment the index and go to SEND.
- `tx_data` is registered and holds its value until the next SEND. After a frame it keeps the final 0x0A.
- Gap counter width is sized by $clog2(BYTE_GAP+1). The counter never wraps; it is reloaded only in SEND.
- The char index wraps to 0 only on acceptance of a new word.
- `in_valid` is ignored outside IDLE. A word offered while `busy` stays pending on the bus until `in_ready` rises. No input buffering.
- Reset asserted at any time, including mid-word:
  - state goes to IDLE immediately (asynchronous);
  - `tx_start`=0, `tx_data`=0x00, `busy`=0, `in_ready`=1;
  - the partial word is discarded, and no further pulses occur for it.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0x00, `busy`=0, `in_ready`=1.
- Handshake: transfer occurs at the rising edge where `in_valid`=1 and `in_ready`=1 (cycle T).
- `busy`=1 and `in_ready`=0 from T+1.
- The first `tx_start` pulse is at cycle T+1. Character k is pulsed at T+1+k*BYTE_GAP, for k = 0..NCHAR-1.
- `tx_start` is never high in two consecutive cycles.
- Return to IDLE: `in_ready`=1 and `busy`=0 at cycle T+1+NCHAR*BYTE_GAP.
- A new word can be accepted in that same cycle, so its first pulse is at T+2+NCHAR*BYTE_GAP.
- Worst-case throughput is one word per NCHAR*BYTE_GAP+1 cycles.

## Test plan
Bench settings: CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BYTE_GAP=120; DATA_WIDTH=32, so NCHAR=10.
- **Basic word:** send 0xDEADBEEF, accepted at T.
  - Required byte sequence: 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A.
  - Pulses at T+1, T+121, …, T+1081.
  - `in_ready` high again at T+1201.
- **Encoding boundaries:** send 0x09AF09AF.
  - Required bytes: 0x30 0x39 0x41 0x46 0x30 0x39 0x41 0x46 0x0D 0x0A.
  - Send 0x00000000 and 0xFFFFFFFF and check for eight 0x30 and eight 0x46 respectively.
- **Back-to-back:** hold `in_valid`=1 with 0x12345678, then 0x9ABCDEF0.
  - The second word is accepted at exactly T+1201.
  - Its first pulse (0x39) is at T+1202.
  - No dropped or duplicated bytes.
- **Capture isolation:** change `in_data` every cycle after acceptance of 0xCAFEF00D.
  - Output is still 0x43 0x41 0x46 0x45 0x46 0x30 0x30 0x44 0x0D 0x0A.
- **Reset mid-word:** assert `reset_n`=0 for 3 cycles, 10 cycles after the third pulse.
  - `tx_start`=0, `tx_data`=0x00, and `busy`=0 immediately.
  - `in_ready`=1 after release, with no further pulses.
  - The next word starts from its first character.
- **System check:** connect the team's UART transmitter downstream and decode the line.
  - All 10 frames arrive intact for 0xDEADBEEF, with no start bit overlapping the previous stop bit.
